// File: rtl/exec_wb_buf.sv
// Two-entry skid buffer between the execute units and writeback.
// It also holds the architectural flags register, which commits on retire.
module exec_wb_buf #(
  parameter int W_OPR   = 32,
  parameter int W_FLAGS = 4,
  parameter int W_REG   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [W_OPR-1:0]   in_result_i,
  input  logic [W_FLAGS-1:0] in_flags_i,
  input  logic [W_REG-1:0]   in_rd_i,
  input  logic               in_we_i,
  input  logic               in_fwe_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [W_OPR-1:0]   out_result_o,
  output logic [W_REG-1:0]   out_rd_o,
  output logic               out_we_o,
  output logic [W_FLAGS-1:0] flags_o,
  output logic [1:0]         count_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready
  // are both 1. Valid must not depend on ready, and in_ready_o is a pure
  // decode of registered state, so it has no path from out_ready_i.

  // The state encoding equals the occupancy, so count_o exposes the FSM.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]         state_q;
  logic [1:0]         state_d;

  logic [W_OPR-1:0]   head_result_q;
  logic [W_FLAGS-1:0] head_flags_q;
  logic [W_REG-1:0]   head_rd_q;
  logic               head_we_q;
  logic               head_fwe_q;

  logic [W_OPR-1:0]   skid_result_q;
  logic [W_FLAGS-1:0] skid_flags_q;
  logic [W_REG-1:0]   skid_rd_q;
  logic               skid_we_q;
  logic               skid_fwe_q;

  logic [W_FLAGS-1:0] flags_q;

  logic head_valid;
  logic skid_valid;
  logic push;
  logic pop;
  logic load_head_in;
  logic load_head_skid;
  logic load_skid;

  assign head_valid = (state_q != ST_EMPTY);
  assign skid_valid = (state_q == ST_FULL);

  assign in_ready_o = ~skid_valid;
  assign pop        = head_valid & out_ready_i;
  assign push       = in_valid_i & in_ready_o & ~flush_i;

  // A push only happens while skid is empty, so head is free for the new
  // entry whenever it is empty or leaving on this edge.
  assign load_head_in   = push & (~head_valid | pop);
  assign load_head_skid = pop & skid_valid;
  assign load_skid      = push & head_valid & ~pop;

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (push) state_d = ST_ONE;
        ST_ONE: begin
          if (push && !pop)      state_d = ST_FULL;
          else if (!push && pop) state_d = ST_EMPTY;
        end
        ST_FULL:  if (pop) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_result_q <= '0;
      head_flags_q  <= '0;
      head_rd_q     <= '0;
      head_we_q     <= 1'b0;
      head_fwe_q    <= 1'b0;
    end else if (load_head_skid) begin
      head_result_q <= skid_result_q;
      head_flags_q  <= skid_flags_q;
      head_rd_q     <= skid_rd_q;
      head_we_q     <= skid_we_q;
      head_fwe_q    <= skid_fwe_q;
    end else if (load_head_in) begin
      head_result_q <= in_result_i;
      head_flags_q  <= in_flags_i;
      head_rd_q     <= in_rd_i;
      head_we_q     <= in_we_i;
      head_fwe_q    <= in_fwe_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_result_q <= '0;
      skid_flags_q  <= '0;
      skid_rd_q     <= '0;
      skid_we_q     <= 1'b0;
      skid_fwe_q    <= 1'b0;
    end else if (load_skid) begin
      skid_result_q <= in_result_i;
      skid_flags_q  <= in_flags_i;
      skid_rd_q     <= in_rd_i;
      skid_we_q     <= in_we_i;
      skid_fwe_q    <= in_fwe_i;
    end
  end

  // Writeback has seen a retire even in a flush cycle, so it still commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else if (pop && head_fwe_q) begin
      flags_q <= head_flags_q;
    end
  end

  assign out_valid_o  = head_valid;
  assign out_result_o = head_result_q;
  assign out_rd_o     = head_rd_q;
  assign out_we_o     = head_valid & head_we_q;
  assign flags_o      = flags_q;
  assign count_o      = state_q;

endmodule

// File: tb/tb_exec_wb_buf.sv
// Directed bench for exec_wb_buf: vector table plus hand-written reset sequences.
module tb_exec_wb_buf;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_result_i;
  logic [3:0]  in_flags_i;
  logic [3:0]  in_rd_i;
  logic        in_we_i;
  logic        in_fwe_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_result_o;
  logic [3:0]  out_rd_o;
  logic        out_we_o;
  logic [3:0]  flags_o;
  logic [1:0]  count_o;

  int n_checks;
  int n_fails;
  logic [31:0] exp_q[$];

  exec_wb_buf #(.W_OPR(32), .W_FLAGS(4), .W_REG(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_result_i  (in_result_i),
    .in_flags_i   (in_flags_i),
    .in_rd_i      (in_rd_i),
    .in_we_i      (in_we_i),
    .in_fwe_i     (in_fwe_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_result_o (out_result_o),
    .out_rd_o     (out_rd_o),
    .out_we_o     (out_we_o),
    .flags_o      (flags_o),
    .count_o      (count_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        iv;
    logic [31:0] res;
    logic [3:0]  fl;
    logic [3:0]  rd;
    logic        we;
    logic        fwe;
    logic        ordy;
    logic        e_ov;
    logic        e_ir;
    logic [31:0] e_res;
    logic [3:0]  e_rd;
    logic        e_we;
    logic [3:0]  e_fl;
    logic [1:0]  e_cnt;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(logic flush, logic iv, logic [31:0] res, logic [3:0] fl,
                              logic [3:0] rd, logic we, logic fwe, logic ordy,
                              logic e_ov, logic e_ir, logic [31:0] e_res, logic [3:0] e_rd,
                              logic e_we, logic [3:0] e_fl, logic [1:0] e_cnt);
    vec_t v;
    v.flush = flush; v.iv = iv; v.res = res; v.fl = fl; v.rd = rd;
    v.we = we; v.fwe = fwe; v.ordy = ordy;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_res = e_res; v.e_rd = e_rd;
    v.e_we = e_we; v.e_fl = e_fl; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive(input vec_t v);
    flush_i     = v.flush;
    in_valid_i  = v.iv;
    in_result_i = v.res;
    in_flags_i  = v.fl;
    in_rd_i     = v.rd;
    in_we_i     = v.we;
    in_fwe_i    = v.fwe;
    out_ready_i = v.ordy;
  endtask

  task automatic idle(input logic ordy);
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    in_result_i = '0;
    in_flags_i  = '0;
    in_rd_i     = '0;
    in_we_i     = 1'b0;
    in_fwe_i    = 1'b0;
    out_ready_i = ordy;
  endtask

  // scoreboard: every retire must match the next expected result in order
  always @(negedge clk) begin
    if (!rst && out_valid_o && out_ready_i) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fails++;
        $display("FAIL retire_order: unexpected retire of 0x%0h, none expected", out_result_o);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (out_result_o !== e) begin
          n_fails++;
          $display("FAIL retire_order: got 0x%0h, expected 0x%0h", out_result_o, e);
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fails  = 0;
    idle(1'b0);
    rst = 1'b1;

    // columns: flush iv res fl rd we fwe ordy | ov ir res rd we flags count
    // streaming
    vecs[0]  = mk(0,1,32'd10,4'b0001,4'd1,1,1,1, 1,1,32'd10,4'd1,1,4'b0000,2'd1);
    vecs[1]  = mk(0,1,32'd20,4'b0010,4'd2,1,1,1, 1,1,32'd20,4'd2,1,4'b0001,2'd1);
    vecs[2]  = mk(0,1,32'd30,4'b1000,4'd3,1,1,1, 1,1,32'd30,4'd3,1,4'b0010,2'd1);
    vecs[3]  = mk(0,0,32'd0, 4'b0000,4'd0,0,0,1, 0,1,32'd0, 4'd0,0,4'b1000,2'd0);
    // backpressure: A, B fill, C held until writeback drains
    vecs[4]  = mk(0,1,32'h5,4'b0000,4'd4,1,0,0, 1,1,32'h5,4'd4,1,4'b1000,2'd1);
    vecs[5]  = mk(0,1,32'h7,4'b0000,4'd5,0,0,0, 1,0,32'h5,4'd4,1,4'b1000,2'd2);
    vecs[6]  = mk(0,1,32'h9,4'b0000,4'd6,1,0,0, 1,0,32'h5,4'd4,1,4'b1000,2'd2);
    vecs[7]  = mk(0,1,32'h9,4'b0000,4'd6,1,0,1, 1,1,32'h7,4'd5,0,4'b1000,2'd1);
    vecs[8]  = mk(0,1,32'h9,4'b0000,4'd6,1,0,1, 1,1,32'h9,4'd6,1,4'b1000,2'd1);
    vecs[9]  = mk(0,0,32'h0,4'b0000,4'd0,0,0,1, 0,1,32'h0,4'd0,0,4'b1000,2'd0);
    // flag gating
    vecs[10] = mk(0,1,32'h11,4'b1010,4'd7,1,1,0, 1,1,32'h11,4'd7,1,4'b1000,2'd1);
    vecs[11] = mk(0,1,32'h0, 4'b0100,4'd8,1,0,0, 1,0,32'h11,4'd7,1,4'b1000,2'd2);
    vecs[12] = mk(0,0,32'h0, 4'b0000,4'd0,0,0,1, 1,1,32'h0, 4'd8,1,4'b1010,2'd1);
    vecs[13] = mk(0,0,32'h0, 4'b0000,4'd0,0,0,1, 0,1,32'h0, 4'd0,0,4'b1010,2'd0);
    // flush with two entries, retire and input in the same cycle
    vecs[14] = mk(0,1,32'h21,4'b0011,4'd9, 1,1,0, 1,1,32'h21,4'd9,1,4'b1010,2'd1);
    vecs[15] = mk(0,1,32'h22,4'b0101,4'd10,1,1,0, 1,0,32'h21,4'd9,1,4'b1010,2'd2);
    vecs[16] = mk(1,1,32'h23,4'b1100,4'd11,1,1,1, 0,1,32'h0,4'd0,0,4'b0011,2'd0);
    // flush drops an input that would otherwise be accepted
    vecs[17] = mk(1,1,32'h24,4'b1111,4'd12,1,1,0, 0,1,32'h0,4'd0,0,4'b0011,2'd0);
    vecs[18] = mk(0,0,32'h0, 4'b0000,4'd0, 0,0,1, 0,1,32'h0,4'd0,0,4'b0011,2'd0);
    vecs[19] = mk(0,1,32'h25,4'b0110,4'd13,0,1,1, 1,1,32'h25,4'd13,0,4'b0011,2'd1);
    vecs[20] = mk(0,0,32'h0, 4'b0000,4'd0, 0,0,1, 0,1,32'h0,4'd0,0,4'b0110,2'd0);

    exp_q = '{32'd10, 32'd20, 32'd30, 32'h5, 32'h7, 32'h9, 32'h11, 32'h0, 32'h21, 32'h25};

    // reset state
    #12;
    check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready_o},  32'd1);
    check("rst_count",     {30'd0, count_o},     32'd0);
    check("rst_flags",     {28'd0, flags_o},     32'd0);
    check("rst_out_we",    {31'd0, out_we_o},    32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_out_valid", i), {31'd0, out_valid_o}, {31'd0, vecs[i].e_ov});
      check($sformatf("v%0d_in_ready", i),  {31'd0, in_ready_o},  {31'd0, vecs[i].e_ir});
      check($sformatf("v%0d_count", i),     {30'd0, count_o},     {30'd0, vecs[i].e_cnt});
      check($sformatf("v%0d_flags", i),     {28'd0, flags_o},     {28'd0, vecs[i].e_fl});
      check($sformatf("v%0d_out_we", i),    {31'd0, out_we_o},    {31'd0, vecs[i].e_we});
      if (vecs[i].e_ov) begin
        check($sformatf("v%0d_result", i), out_result_o, vecs[i].e_res);
        check($sformatf("v%0d_rd", i),     {28'd0, out_rd_o}, {28'd0, vecs[i].e_rd});
      end
    end

    // async reset mid-stream with two entries held
    idle(1'b0);
    in_valid_i = 1'b1; in_result_i = 32'h31; in_flags_i = 4'b1111; in_fwe_i = 1'b1; in_we_i = 1'b1;
    @(posedge clk);
    #1;
    in_result_i = 32'h32;
    @(posedge clk);
    #1;
    idle(1'b0);
    check("pre_rst_count", {30'd0, count_o}, 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("async_out_valid", {31'd0, out_valid_o}, 32'd0);
    check("async_count",     {30'd0, count_o},     32'd0);
    check("async_in_ready",  {31'd0, in_ready_o},  32'd1);
    check("async_out_we",    {31'd0, out_we_o},    32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_rst%0d_out_valid", k), {31'd0, out_valid_o}, 32'd0);
      check($sformatf("post_rst%0d_flags", k),     {28'd0, flags_o},     32'd0);
    end

    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/exec_wb_buf.md
# exec_wb_buf

Two-entry skid buffer between the execute units (ALU, shift, mul, div) and writeback. It captures each execute result and its `{overflow, sign, zero, carry}` flags, along with the destination-register and write-enable sidebands. It holds them under valid/ready backpressure so a writeback stall never drops a divider or ALU result. It also owns the architectural flags register, which is committed only when an entry retires to writeback.

## Interface
- `W_OPR`, 32, operand/result width (shared with exec units)
- `W_FLAGS`, 4, flags width, packed `{overflow, sign, zero, carry}`
- `W_REG`, 4, destination register index width
- `clk`  in  1  the single clock; all state on rising edge
- `rst`  in  1  reset; asynchronous and active-high
- `flush_i`  in  1  pipeline flush (branch mispredict/exception)
- `in_valid_i`  in  1  execute result valid
- `in_ready_o`  out  1  buffer can accept
- `in_result_i`  in  W_OPR  execute result
- `in_flags_i`  in  W_FLAGS  execute flags
- `in_rd_i`  in  W_REG  destination register
- `in_we_i`  in  1  register write enable
- `in_fwe_i`  in  1  flags write enable
- `out_valid_o`  out  1  head entry valid
- `out_ready_i`  in  1  writeback accepts
- `out_result_o`  out  W_OPR  head result
- `out_rd_o`  out  W_REG  head destination
- `out_we_o`  out  1  head register write enable, gated by `out_valid_o`
- `flags_o`  out  W_FLAGS  architectural flags register
- `count_o`  out  2  occupancy, 0..2

## Operation
- Storage: two entries, `head` and `skid`, each holding result, flags, rd, we and fwe, plus a valid bit. Outputs are driven from `head` only.
- Accept: when `in_valid_i & in_ready_o & ~flush_i`:
  - goes into `head` if `head` will be empty after this cycle's pop,
  - otherwise goes into `skid`.
- Retire: when `out_valid_o & out_ready_i`, `head` leaves. If `skid` is valid it moves into `head` on the same edge. If `skid` is empty and an accept occurs, the new entry goes directly to `head`.
- States by occupancy:
  - EMPTY→ONE on accept.
  - ONE→ONE on accept together with retire.
  - ONE→FULL on accept without retire.
  - FULL→ONE on retire. FULL never accepts, because `in_ready_o` is 0.
  - ONE→EMPTY on retire without accept.
- `in_ready_o = ~skid_valid`. It is registered and has no combinational path from `out_ready_i`.
- Flags commit: on retire with head.fwe=1, `flags_o <= head.flags`. Entries with fwe=0 leave `flags_o` unchanged. The flags of entries that have not yet retired are never visible on `flags_o`.
- Flush: `flush_i` clears both valid bits on the next edge.
  - An input presented in the flush cycle is dropped.
  - A retire in the flush cycle still happens, and its flags still commit, because writeback saw it.
  - `flags_o` is not otherwise modified.
- Data fields of invalid entries are don't-care, but `out_we_o` must be 0 whenever `out_valid_o` is 0.

## Timing
- Reset values (asynchronous, immediate): `out_valid_o`=0, `in_ready_o`=1, `count_o`=0, `flags_o`=4'b0000, `out_we_o`=0. Data registers are cleared to 0.
- Latency: an entry accepted at edge N is on the outputs with `out_valid_o`=1 after edge N. That is 1 cycle from input handshake to output visibility.
- Throughput: 1 entry/cycle sustained when `out_ready_i`=1.
- `flags_o` updates on the same edge as the retire handshake.
- Reset asserted mid-operation discards all entries. The bench must not see a stale entry retire after reset is released.

## Test plan
- Reset then idle: `rst`=1 → `out_valid_o`=0, `in_ready_o`=1, `count_o`=0, `flags_o`=0000.
- Streaming, `out_ready_i`=1, results 10, 20, 30 on consecutive cycles with fwe=1 and flags 0001, 0010, 1000:
  - each result appears one cycle later;
  - `flags_o` follows 0001→0010→1000 on each retire edge;
  - `count_o` stays 1.
- Backpressure, `out_ready_i`=0:
  - accept A=0x5, then B=0x7 → `count_o`=2, `in_ready_o`=0;
  - C=0x9 held until `out_ready_i`=1;
  - outputs then appear in order 5, 7, 9 with nothing lost or duplicated.
- Flag gating: retire {result=0, flags=0100, fwe=0} after {flags=1010, fwe=1} → `flags_o` stays 1010.
- Flush:
  - with two entries, `flush_i`=1 together with `out_ready_i`=1 and head flags 0011 fwe=1 → head retires, `flags_o`=0011, `count_o`=0;
  - an input presented in that cycle is dropped.
- Async reset mid-stream: assert `rst` with `count_o`=2 → `out_valid_o`=0 immediately without a clock edge; after release, no stale output appears.
